ps2_message_builder: RTL and testbench

PS2_MESSAGE_BUILDER -- requirements
Module: ps2_message_builder

---
 rtl/ps2_msg_pkg.sv | 23 ++
 rtl/ps2_scancode_to_ascii.sv | 54 +++++
 rtl/ps2_message_builder.sv | 161 ++++++++++++++++
 tb/tb_ps2_message_builder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_msg_pkg.sv
// ps2_msg_pkg
// Shared definitions for the PS/2 message builder: the control-FSM state
// type and the scan-code / ASCII constants used by the translator and the
// buffer logic.
package ps2_msg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    SEND_WAIT = 2'd2
  } state_e;

  // Set-2 prefix bytes.
  localparam logic [7:0] BREAK_CODE  = 8'hF0;
  localparam logic [7:0] EXT_CODE    = 8'hE0;

  // Scan code of the Backspace key, and the ASCII values the buffer uses.
  localparam logic [7:0] DEL_CODE    = 8'h66;
  localparam logic [7:0] SPACE_CODE  = 8'h29;
  localparam logic [7:0] ASCII_DEL   = 8'd127;
  localparam logic [7:0] ASCII_SPACE = 8'd32;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// ps2_scancode_to_ascii
// Purely combinational PS/2 set-2 scan code to ASCII translator.
// Covers the letters a-z, space, and Backspace (reported as ASCII DEL).
// Ports:
//   code   [7:0] in   raw scan code
//   ascii  [7:0] out  translated character (0 when unmapped)
//   mapped       out  1 when code is one of the supported keys
module ps2_scancode_to_ascii
  import ps2_msg_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii,
  output logic       mapped
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    ascii  = 8'h00;
    mapped = 1'b1;
    unique case (code)
      8'h1C: ascii = "a";
      8'h32: ascii = "b";
      8'h21: ascii = "c";
      8'h23: ascii = "d";
      8'h24: ascii = "e";
      8'h2B: ascii = "f";
      8'h34: ascii = "g";
      8'h33: ascii = "h";
      8'h43: ascii = "i";
      8'h3B: ascii = "j";
      8'h42: ascii = "k";
      8'h4B: ascii = "l";
      8'h3A: ascii = "m";
      8'h31: ascii = "n";
      8'h44: ascii = "o";
      8'h4D: ascii = "p";
      8'h15: ascii = "q";
      8'h2D: ascii = "r";
      8'h1B: ascii = "s";
      8'h2C: ascii = "t";
      8'h3C: ascii = "u";
      8'h2A: ascii = "v";
      8'h1D: ascii = "w";
      8'h22: ascii = "x";
      8'h35: ascii = "y";
      8'h1A: ascii = "z";
      SPACE_CODE: ascii = ASCII_SPACE;
      DEL_CODE:   ascii = ASCII_DEL;
      default:    mapped = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_message_builder.sv
// ps2_message_builder
// Collects typed PS/2 keys into a packed ASCII message buffer and hands the
// buffer to a GPIO link on request. Character 0 (first typed) occupies the
// most-significant byte of message_out; unused bytes are zero.
// Key releases (F0 xx) are swallowed, E0 prefixes are dropped, Backspace
// removes the last character. While a transfer is pending (SEND_WAIT) the
// buffer is frozen until the link reports done, which clears it.
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   key_valid, key_code  one-cycle scan code strobe and code
//   send                 one-cycle transmit request
//   done                 transmitter-complete level
//   message_out          packed ASCII buffer, 8*MSG_CHARS bits
//   msg_len              number of valid characters
//   data_ready           buffer-valid level to the link
//   lcd_char, lcd_char_valid  echo of each accepted append/delete
// Build option: define PS2_MSG_ECHO_EN to compile in the echo outputs;
// otherwise they are tied to zero and no echo registers exist.
// MSG_CHARS must be at least 2.
module ps2_message_builder
  import ps2_msg_pkg::*;
#(
  parameter int MSG_CHARS = 16,
  localparam int LEN_W = $clog2(MSG_CHARS + 1),
  localparam int IDX_W = $clog2(MSG_CHARS)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   key_valid,
  input  logic [7:0]             key_code,
  input  logic                   send,
  input  logic                   done,
  output logic [8*MSG_CHARS-1:0] message_out,
  output logic [LEN_W-1:0]       msg_len,
  output logic                   data_ready,
  output logic [7:0]             lcd_char,
  output logic                   lcd_char_valid
);

  // Element [MSG_CHARS-1] is the MSB byte, so character i lives in element
  // MSG_CHARS-1-i and the packed array maps straight onto message_out.
  typedef logic [MSG_CHARS-1:0][7:0] buf_t;

  state_e           state_q, state_d;
  buf_t             buf_q, buf_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ready_q, ready_d;
  logic             echo_fire;

  logic [7:0]       ascii;
  logic             mapped;
  logic [IDX_W-1:0] ins_idx;
  logic [IDX_W-1:0] del_idx;

  ps2_scancode_to_ascii u_xlate (
    .code   (key_code),
    .ascii  (ascii),
    .mapped (mapped)
  );

  // Element holding the next free slot, and the last used slot. Only used
  // under the guards below (len < MSG_CHARS / len > 0), so wrap is harmless.
  assign ins_idx = IDX_W'(MSG_CHARS - 1) - IDX_W'(len_q);
  assign del_idx = IDX_W'(MSG_CHARS) - IDX_W'(len_q);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    len_d     = len_q;
    ready_d   = ready_q;
    echo_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send) begin
          // A send always consumes the cycle; any key alongside it is lost.
          if (len_q != '0) begin
            state_d = SEND_WAIT;
            ready_d = 1'b1;
          end
        end else if (key_valid) begin
          if (key_code == BREAK_CODE) begin
            state_d = BREAK;
          end else if (mapped && key_code != EXT_CODE) begin
            if (ascii == ASCII_DEL) begin
              if (len_q != '0) begin
                buf_d[del_idx] = 8'h00;
                len_d          = len_q - LEN_W'(1);
                echo_fire      = 1'b1;
              end
            end else if (len_q < LEN_W'(MSG_CHARS)) begin
              buf_d[ins_idx] = ascii;
              len_d          = len_q + LEN_W'(1);
              echo_fire      = 1'b1;
            end
          end
        end
      end
      BREAK: begin
        // The code after F0 names the released key; it is discarded.
        if (key_valid) state_d = IDLE;
      end
      SEND_WAIT: begin
        if (done) begin
          buf_d   = '0;
          len_d   = '0;
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The message buffer is part of the architectural reset state, so it is
  // cleared with everything else rather than left uninitialised.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples the pre-edge values computed above.
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ready_q <= ready_d;
    end
  end

  assign message_out = buf_q;
  assign msg_len     = len_q;
  assign data_ready  = ready_q;

`ifdef PS2_MSG_ECHO_EN
  logic [7:0] lcd_char_q;
  logic       lcd_valid_q;

  // Echo registers update on the same edge as the buffer, so the strobe is
  // aligned with the visible change. lcd_char holds the last echoed value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lcd_char_q  <= 8'h00;
      lcd_valid_q <= 1'b0;
    end else begin
      lcd_valid_q <= echo_fire;
      if (echo_fire) lcd_char_q <= ascii;
    end
  end

  assign lcd_char       = lcd_char_q;
  assign lcd_char_valid = lcd_valid_q;
`else
  logic unused_echo;
  assign unused_echo    = echo_fire;
  assign lcd_char       = 8'h00;
  assign lcd_char_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_message_builder.sv
// tb_ps2_message_builder
// Self-checking bench for ps2_message_builder. A queue-based model of the
// typed message is updated every rising edge; a compare process checks all
// outputs on every falling edge. Directed sequences pin the model with
// literal values, then a long randomized run exercises mixed traffic.
// Echo expectations follow PS2_MSG_ECHO_EN in the same way as the design.
module tb_ps2_message_builder;

  localparam int N  = 16;
  localparam int LW = $clog2(N + 1);

  logic           clock = 1'b0;
  logic           resetn;
  logic           key_valid;
  logic [7:0]     key_code;
  logic           send;
  logic           done;
  logic [8*N-1:0] message_out;
  logic [LW-1:0]  msg_len;
  logic           data_ready;
  logic [7:0]     lcd_char;
  logic           lcd_char_valid;

  ps2_message_builder #(.MSG_CHARS(N)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .send           (send),
    .done           (done),
    .message_out    (message_out),
    .msg_len        (msg_len),
    .data_ready     (data_ready),
    .lcd_char       (lcd_char),
    .lcd_char_valid (lcd_char_valid)
  );

  always #5 clock = ~clock;

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit bench_done = 1'b0;

  task automatic check(input string name, input logic [8*N-1:0] act,
                       input logic [8*N-1:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Set-2 codes of the letters a..z, in alphabetical order.
  logic [7:0] sc_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                              8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                              8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                              8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic bit printable(input logic [7:0] c, output logic [7:0] ch);
    ch = 8'h00;
    if (c == 8'h29) begin ch = 8'd32; return 1'b1; end
    for (int i = 0; i < 26; i++)
      if (c == sc_tab[i]) begin ch = 8'(97 + i); return 1'b1; end
    return 1'b0;
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];        // typed characters, oldest first
  bit         m_wait;       // transfer pending
  bit         m_release;    // next code is a key release
  logic [7:0] m_lcd;
  bit         m_lcd_v;

  always @(posedge clock or negedge resetn) begin
    logic [7:0] ch;
    if (!resetn) begin
      mq.delete();
      m_wait = 0; m_release = 0; m_lcd = 0; m_lcd_v = 0;
    end else begin
      m_lcd_v = 0;
      if (m_wait) begin
        if (done) begin mq.delete(); m_wait = 0; end
      end else if (m_release) begin
        if (key_valid) m_release = 0;
      end else if (send) begin
        if (mq.size() > 0) m_wait = 1;
      end else if (key_valid) begin
        if (key_code == 8'hF0) m_release = 1;
        else if (key_code == 8'h66) begin
          if (mq.size() > 0) begin
            void'(mq.pop_back());
            m_lcd = 8'd127; m_lcd_v = 1;
          end
        end else if (printable(key_code, ch) && mq.size() < N) begin
          mq.push_back(ch);
          m_lcd = ch; m_lcd_v = 1;
        end
      end
    end
  end

  function automatic logic [8*N-1:0] model_msg();
    logic [8*N-1:0] r = '0;
    foreach (mq[i]) r[8*(N-1-i) +: 8] = mq[i];
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!bench_done) begin
      check("cyc_msg", message_out, model_msg());
      check("cyc_len", (8*N)'(msg_len), (8*N)'(mq.size()));
      check("cyc_rdy", (8*N)'(data_ready), (8*N)'(m_wait));
`ifdef PS2_MSG_ECHO_EN
      check("cyc_lcd_v", (8*N)'(lcd_char_valid), (8*N)'(m_lcd_v));
      check("cyc_lcd", (8*N)'(lcd_char), (8*N)'(m_lcd));
`else
      check("cyc_lcd_v", (8*N)'(lcd_char_valid), '0);
      check("cyc_lcd", (8*N)'(lcd_char), '0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  // Apply inputs for one clock, then sample just after the edge.
  task automatic cycle(input bit kv, input logic [7:0] kc, input bit snd,
                       input bit dn);
    key_valid = kv; key_code = kc; send = snd; done = dn;
    @(posedge clock);
    #1;
    key_valid = 0; send = 0; done = 0;
  endtask

  task automatic key(input logic [7:0] kc);
    cycle(1'b1, kc, 1'b0, 1'b0);
  endtask

  task automatic chk_echo(input string name, input bit v, input logic [7:0] c);
`ifdef PS2_MSG_ECHO_EN
    check({name, "_v"}, (8*N)'(lcd_char_valid), (8*N)'(v));
    if (v) check({name, "_c"}, (8*N)'(lcd_char), (8*N)'(c));
`else
    check({name, "_v"}, (8*N)'(lcd_char_valid), '0);
    check({name, "_c"}, (8*N)'(lcd_char), '0);
`endif
  endtask

  task automatic flush();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    resetn = 0; key_valid = 0; key_code = 0; send = 0; done = 0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_msg", message_out, '0);
    check("rst_len", (8*N)'(msg_len), '0);
    check("rst_rdy", (8*N)'(data_ready), '0);
    chk_echo("rst_echo", 1'b0, 8'h00);
    @(negedge clock);
    resetn = 1;

    // "hi": first key honoured on the first edge after reset release
    key(8'h33);
    chk_echo("h_echo", 1'b1, 8'h68);
    key(8'h43);
    chk_echo("i_echo", 1'b1, 8'h69);
    check("hi_len", (8*N)'(msg_len), 2);
    check("hi_top", (8*N)'(message_out[8*N-1 -: 16]), 16'h6869);
    check("hi_rest", (8*N)'(message_out[8*N-17:0]), '0);

    // send, ignored key while waiting, done clears
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("snd_rdy", (8*N)'(data_ready), 1);
    key(8'h1C);
    check("wait_len", (8*N)'(msg_len), 2);
    check("wait_msg", (8*N)'(message_out[8*N-1 -: 16]), 16'h6869);
    chk_echo("wait_echo", 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("done_rdy", (8*N)'(data_ready), 0);
    check("done_len", (8*N)'(msg_len), 0);
    check("done_msg", message_out, '0);

    // make + break of 'a'
    key(8'h1C); key(8'hF0); key(8'h1C);
    check("brk_len", (8*N)'(msg_len), 1);
    check("brk_msg", message_out, {8'h61, {(N-1){8'h00}}});
    flush();

    // fill to capacity, overflow, then delete
    repeat (N) key(8'h1C);
    check("full_len", (8*N)'(msg_len), N);
    check("full_msg", message_out, {N{8'h61}});
    key(8'h1C);
    check("ovf_len", (8*N)'(msg_len), N);
    chk_echo("ovf_echo", 1'b0, 8'h00);
    key(8'h66);
    check("del_len", (8*N)'(msg_len), N-1);
    check("del_msg", message_out, {{(N-1){8'h61}}, 8'h00});
    chk_echo("del_echo", 1'b1, 8'd127);
    flush();

    // empty buffer: delete and send are both no-ops
    key(8'h66);
    check("edel_len", (8*N)'(msg_len), 0);
    chk_echo("edel_echo", 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("esnd_rdy", (8*N)'(data_ready), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("esnd_rdy2", (8*N)'(data_ready), 0);

    // asynchronous reset in the middle of a pending transfer
    key(8'h33);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_rdy", (8*N)'(data_ready), 1);
    #2 resetn = 0;
    #1;
    check("arst_msg", message_out, '0);
    check("arst_len", (8*N)'(msg_len), '0);
    check("arst_rdy", (8*N)'(data_ready), '0);
    chk_echo("arst_echo", 1'b0, 8'h00);
    @(negedge clock);
    resetn = 1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("late_done_rdy", (8*N)'(data_ready), 0);
    check("late_done_len", (8*N)'(msg_len), 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit         kv, snd, dn;
      logic [7:0] kc;
      int         sel;
      kv  = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: kc = sc_tab[$urandom_range(0, 25)];
        5:       kc = 8'h29;
        6:       kc = 8'h66;
        7:       kc = 8'hF0;
        8:       kc = 8'hE0;
        default: kc = 8'($urandom_range(0, 255));
      endcase
      snd = ($urandom_range(0, 39) == 0);
      dn  = ($urandom_range(0, 3) == 0);
      if (snd && mq.size() == 0) kv = 0;
      cycle(kv, kc, snd, dn);
    end

    @(negedge clock);
    bench_done = 1;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
